// File: rtl/tate_pairing_host_if_pkg.sv
// Shared constants for the Tate pairing host interface: default sizing and FSM encodings.
package tate_pairing_host_if_pkg;

   localparam int unsigned M_DEF       = 97;
   localparam int unsigned DW_DEF      = 32;
   localparam int unsigned TIMEOUT_DEF = 1000000;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/tp_trit_check.sv
// Flags a 2'b11 trit code anywhere in the low nbits of a stream word.
module tp_trit_check #(
   parameter int unsigned DW = 32
) (
   input  logic [DW-1:0]            word,
   input  logic [$clog2(DW+1)-1:0]  nbits,
   output logic                     bad_c
);

   always_comb begin
      bad_c = 1'b0;
      for (int unsigned i = 0; i < DW / 2; i++) begin
         if ((2 * i + 2) <= 32'(nbits) && word[2*i +: 2] == 2'b11) bad_c = 1'b1;
      end
   end

endmodule

// File: rtl/tate_pairing_host_if.sv
// Word-serial operand loader, start/watchdog sequencer and result streamer for the pairing core.
module tate_pairing_host_if
   import tate_pairing_host_if_pkg::*;
#(
   parameter int unsigned M       = M_DEF,
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DW-1:0]     in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DW-1:0]     out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              err_trit,
   output logic              err_timeout,
   output logic              core_reset,
   output logic [2*M-1:0]    core_x1,
   output logic [2*M-1:0]    core_y1,
   output logic [2*M-1:0]    core_x2,
   output logic [2*M-1:0]    core_y2,
   input  logic              core_done,
   input  logic [12*M-1:0]   core_out
);

   localparam int unsigned WIDTH = 2 * M;
   localparam int unsigned W6    = 12 * M;
   localparam int unsigned OPW   = ceil_div(WIDTH, DW);
   localparam int unsigned RW    = ceil_div(W6, DW);
   localparam int unsigned LASTB = WIDTH - (OPW - 1) * DW;
   localparam int unsigned CW    = $clog2(DW + 1);
   localparam int unsigned WDW   = $clog2(OPW);
   localparam int unsigned KW    = $clog2(RW);
   localparam int unsigned TW    = $clog2(TIMEOUT);
   localparam int unsigned RBW   = $clog2(RW * DW);

   logic [1:0]      state, state_nxt;
   logic [1:0]      op_idx, op_nxt;
   logic [WDW-1:0]  wd_idx, wd_nxt;
   logic [KW-1:0]   k, k_nxt, k_sel;
   logic [TW-1:0]   wdog, wdog_nxt;
   logic            bad, bad_nxt;
   logic            busy_nxt, err_trit_nxt, err_to_nxt;
   logic            in_ready_nxt, core_reset_nxt;
   logic            out_valid_nxt, out_last_nxt;
   logic [DW-1:0]   out_data_nxt;

   logic            acc, out_hs, first_c, last_slot_c, trit_bad_c;
   logic [CW-1:0]   nbits_c;
   logic [RW*DW-1:0] res_pad;
   logic [DW-1:0]   word_c;

   logic [DW-1:0]    full_q [4][OPW-1];
   logic [LASTB-1:0] tail_q [4];
   logic [WIDTH-1:0] flat   [4];

   assign acc         = in_valid && in_ready;
   assign out_hs      = out_valid && out_ready;
   assign last_slot_c = (wd_idx == WDW'(OPW - 1));
   assign first_c     = acc && (op_idx == 2'd0) && (wd_idx == '0);
   assign nbits_c     = last_slot_c ? CW'(LASTB) : CW'(DW);

   tp_trit_check #(.DW(DW)) u_trit (
      .word  (in_data),
      .nbits (nbits_c),
      .bad_c (trit_bad_c)
   );

   // Result word selector: word 0 when leaving BUSY, next word on each drain handshake.
   assign res_pad = (RW * DW)'(core_out);
   assign k_sel   = (state == DRAIN && k != KW'(RW - 1)) ? k + 1'b1 : '0;
   assign word_c  = res_pad[RBW'(32'(k_sel) * DW) +: DW];

   always_comb begin
      state_nxt     = state;
      op_nxt        = op_idx;
      wd_nxt        = wd_idx;
      k_nxt         = k;
      wdog_nxt      = wdog;
      bad_nxt       = bad;
      busy_nxt      = busy;
      err_trit_nxt  = err_trit;
      err_to_nxt    = err_timeout;
      out_valid_nxt = out_valid;
      out_last_nxt  = out_last;
      out_data_nxt  = out_data;
      case (state)
         IDLE: begin
            if (acc) begin
               if (first_c) begin
                  err_trit_nxt = 1'b0;
                  err_to_nxt   = 1'b0;
                  busy_nxt     = 1'b1;
                  bad_nxt      = trit_bad_c;
               end else begin
                  bad_nxt = bad | trit_bad_c;
               end
               if (last_slot_c) begin
                  wd_nxt = '0;
                  op_nxt = op_idx + 1'b1;
               end else begin
                  wd_nxt = wd_idx + 1'b1;
               end
               if (last_slot_c && op_idx == 2'd3) begin
                  if (bad_nxt) begin
                     err_trit_nxt = 1'b1;
                     busy_nxt     = 1'b0;
                  end else begin
                     state_nxt = START;
                  end
               end
            end
         end
         START: begin
            state_nxt = BUSY;
            wdog_nxt  = '0;
         end
         BUSY: begin
            // core_done has priority over an expiring watchdog
            if (core_done) begin
               state_nxt     = DRAIN;
               k_nxt         = '0;
               out_valid_nxt = 1'b1;
               out_last_nxt  = (RW == 1);
               out_data_nxt  = word_c;
            end else if (wdog == TW'(TIMEOUT - 1)) begin
               state_nxt  = IDLE;
               err_to_nxt = 1'b1;
               busy_nxt   = 1'b0;
            end else begin
               wdog_nxt = wdog + 1'b1;
            end
         end
         DRAIN: begin
            if (out_hs) begin
               if (k == KW'(RW - 1)) begin
                  state_nxt     = IDLE;
                  out_valid_nxt = 1'b0;
                  out_last_nxt  = 1'b0;
                  busy_nxt      = 1'b0;
               end else begin
                  k_nxt        = k + 1'b1;
                  out_data_nxt = word_c;
                  out_last_nxt = (k_nxt == KW'(RW - 1));
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      in_ready_nxt   = (state_nxt == IDLE);
      core_reset_nxt = (state_nxt == IDLE) || (state_nxt == START);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         op_idx      <= '0;
         wd_idx      <= '0;
         k           <= '0;
         wdog        <= '0;
         bad         <= 1'b0;
         busy        <= 1'b0;
         err_trit    <= 1'b0;
         err_timeout <= 1'b0;
         in_ready    <= 1'b0;
         core_reset  <= 1'b1;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_data    <= '0;
      end else begin
         state       <= state_nxt;
         op_idx      <= op_nxt;
         wd_idx      <= wd_nxt;
         k           <= k_nxt;
         wdog        <= wdog_nxt;
         bad         <= bad_nxt;
         busy        <= busy_nxt;
         err_trit    <= err_trit_nxt;
         err_timeout <= err_to_nxt;
         in_ready    <= in_ready_nxt;
         core_reset  <= core_reset_nxt;
         out_valid   <= out_valid_nxt;
         out_last    <= out_last_nxt;
         out_data    <= out_data_nxt;
      end
   end

   // Operand storage; the partial top word keeps only its used bits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int o = 0; o < 4; o++) begin
            tail_q[o] <= '0;
            for (int w = 0; w < int'(OPW) - 1; w++) full_q[o][w] <= '0;
         end
      end else if (acc) begin
         if (last_slot_c) tail_q[op_idx] <= in_data[LASTB-1:0];
         else             full_q[op_idx][wd_idx] <= in_data;
      end
   end

   always_comb begin
      for (int o = 0; o < 4; o++) begin
         flat[o] = '0;
         for (int w = 0; w < int'(OPW) - 1; w++) flat[o][w*DW +: DW] = full_q[o][w];
         flat[o][WIDTH-1 -: LASTB] = tail_q[o];
      end
   end

   assign core_x1 = flat[0];
   assign core_y1 = flat[1];
   assign core_x2 = flat[2];
   assign core_y2 = flat[3];

endmodule

// File: tb/tb_tate_pairing_host_if.sv
// Directed bench for tate_pairing_host_if with a stub pairing core.
module tb_tate_pairing_host_if;

   localparam int unsigned DW    = 32;
   localparam int unsigned WIDTH = 194;
   localparam int unsigned W6    = 1164;
   localparam int unsigned NW    = 28;
   localparam int unsigned RW    = 37;

   logic              clk;
   logic              reset_n;
   logic [DW-1:0]     in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              err_trit;
   logic              err_timeout;
   logic              core_reset;
   logic [WIDTH-1:0]  core_x1, core_y1, core_x2, core_y2;
   logic              core_done;
   logic [W6-1:0]     core_out;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] vec [NW];
   logic          stub_en;
   int            stub_cnt;
   logic          mon_en;
   logic          saw_run;

   tate_pairing_host_if #(.TIMEOUT(100)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .busy        (busy),
      .err_trit    (err_trit),
      .err_timeout (err_timeout),
      .core_reset  (core_reset),
      .core_x1     (core_x1),
      .core_y1     (core_y1),
      .core_x2     (core_x2),
      .core_y2     (core_y2),
      .core_done   (core_done),
      .core_out    (core_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub core: done 50 cycles after its reset falls, result word i = i.
   always @(posedge clk) begin
      if (core_reset) stub_cnt <= 0;
      else            stub_cnt <= stub_cnt + 1;
   end
   assign core_done = stub_en && !core_reset && (stub_cnt >= 50);

   always @(negedge clk) begin
      if (mon_en && (!core_reset || out_valid)) saw_run <= 1'b1;
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_vec();
      for (int i = 0; i < int'(NW); i++) vec[i] = '0;
   endtask

   task automatic send_word(input logic [DW-1:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check("in_ready_wait", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_load();
      for (int i = 0; i < int'(NW); i++) begin
         send_word(vec[i]);
         if (i == 0) begin
            check("first_clr_trit", err_trit, 0);
            check("first_clr_to", err_timeout, 0);
            check("first_busy", busy, 1);
         end
      end
   endtask

   task automatic drain(input bit bp, input int stop_at, output int got);
      int k;
      int cyc;
      int j;
      logic [5:0] patv;
      patv = 6'b101001;
      k = 0; cyc = 0; j = 0;
      while (k < int'(RW) && cyc < 2000) begin
         out_ready = bp ? patv[j % 6] : 1'b1;
         @(negedge clk);
         if (out_valid) begin
            j++;
            check("out_data", out_data, 256'(k));
            check("out_last", out_last, 256'(k == 36));
            if (k == 36) check("w36_upper", out_data[31:12], 0);
            if (out_ready) k++;
         end
         @(posedge clk); #1;
         cyc++;
         if (stop_at > 0 && k == stop_at) break;
      end
      if (cyc >= 2000) check("drain_timeout", 0, 1);
      out_ready = 1'b0;
      got = k;
   endtask

   task automatic nominal_vec();
      clear_vec();
      vec[0] = 32'h0000_0001;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int got;
      reset_n   = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      stub_en   = 1'b1;
      mon_en    = 1'b0;
      saw_run   = 1'b0;
      for (int i = 0; i < 36; i++) core_out[i*32 +: 32] = 32'(i);
      core_out[1163:1152] = 12'd36;

      // Reset asserted mid-cycle
      #13 reset_n = 1'b0;
      #1;
      check("rst_core_reset", core_reset, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 check("rel_in_ready_lo", in_ready, 0);
      @(posedge clk); #1;
      check("rel_in_ready_hi", in_ready, 1);

      // Invalid trit in x1 word 5
      clear_vec();
      vec[5] = 32'h0000_0003;
      saw_run = 1'b0;
      mon_en  = 1'b1;
      send_load();
      check("trit_err", err_trit, 1);
      check("trit_busy", busy, 0);
      check("trit_in_ready", in_ready, 1);
      repeat (5) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check("trit_no_run", saw_run, 0);

      // Ignored bits of partial word, core never finishes -> timeout
      clear_vec();
      vec[6] = 32'hFFFF_FFFC;
      stub_en = 1'b0;
      send_load();
      check("to_start_cr", core_reset, 1);
      check("to_no_trit", err_trit, 0);
      check("to_x1_trunc", core_x1, 0);
      n = 0;
      @(posedge clk); #1;
      while (!core_reset && n < 300) begin
         if (n == 0) check("to_early", err_timeout, 0);
         n++;
         @(posedge clk); #1;
      end
      check("to_busy_cycles", n, 100);
      check("to_err", err_timeout, 1);
      check("to_busy", busy, 0);
      check("to_in_ready", in_ready, 1);
      stub_en = 1'b1;

      // Nominal load and drain
      nominal_vec();
      send_load();
      check("nom_x1", core_x1, 1);
      check("nom_y1", core_y1, 0);
      check("nom_x2", core_x2, 0);
      check("nom_y2", core_y2, 0);
      check("nom_start_cr", core_reset, 1);
      check("nom_start_rdy", in_ready, 0);
      check("nom_err_to_clr", err_timeout, 0);
      @(posedge clk); #1;
      check("nom_cr_fall", core_reset, 0);
      drain(1'b0, 0, got);
      check("nom_count", got, 37);
      check("nom_end_valid", out_valid, 0);
      check("nom_end_last", out_last, 0);
      check("nom_end_busy", busy, 0);
      check("nom_end_cr", core_reset, 1);

      // Backpressure with a different operand pattern
      clear_vec();
      vec[17] = 32'h1212_1212;
      vec[27] = 32'h0000_0002;
      send_load();
      check("bp_x1", core_x1, 0);
      check("bp_x2", core_x2, 256'h1212_1212 << 96);
      check("bp_y2", core_y2, 256'h2 << 192);
      drain(1'b1, 0, got);
      check("bp_count", got, 37);
      check("bp_end_valid", out_valid, 0);

      // Reset in the middle of a drain
      nominal_vec();
      send_load();
      drain(1'b0, 10, got);
      check("mid_count", got, 10);
      reset_n = 1'b0;
      #1;
      check("mid_out_valid", out_valid, 0);
      check("mid_core_reset", core_reset, 1);
      check("mid_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("mid_in_ready", in_ready, 1);
      send_load();
      check("fresh_x1", core_x1, 1);
      drain(1'b0, 0, got);
      check("fresh_count", got, 37);
      check("fresh_end_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tate_pairing_host_if.md
Name: tate_pairing_host_if

Overview:
- Host-side front end for the Tate pairing core.
- Accepts the four operands x1, y1, x2, y2 as a word-serial valid/ready stream and packs them into full-width F(3^m) registers.
- Drives the core's active-high synchronous reset as the start pulse, waits for core done under a watchdog, then streams the F(3^6m) result back out word-serially with valid/ready/last.
- Sits between a narrow system bus and the pairing core.

Parameters:
- M, 97: field degree; F(3^m) operand = 2M bits (2 bits per trit), result = 12M bits.
- DW, 32: stream word width.
- TIMEOUT, 1000000: maximum cycles in BUSY before aborting.
- Derived: OPW = ceil(2M/DW) = 7 words per operand; RW = ceil(12M/DW) = 37 result words.

Ports:
- clk  in  1  single clock
- reset_n  in  1  reset, asynchronous, active-low
- in_data  in  DW  operand word
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data
- out_data  out  DW  result word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data
- out_last  out  1  marks final result word
- busy  out  1  high from first accepted word until last result word accepted
- err_trit  out  1  sticky: an operand contained trit code 2'b11
- err_timeout  out  1  sticky: core did not finish within TIMEOUT
- core_reset  out  1  to core reset (active-high, synchronous in core)
- core_x1, core_y1, core_x2, core_y2  out  2M each  operand registers to core
- core_done  in  1  core done
- core_out  in  12M  core result

Behaviour:
- Reset (reset_n low, async):
  - state = IDLE; core_reset = 1; in_ready = 0 while asserted, 1 from the first clk after release.
  - out_valid, out_last, busy, err_* = 0; operand registers cleared; counters = 0.
- States:
  - IDLE/LOAD: in_ready = 1, core_reset = 1. Each in_valid&in_ready stores in_data into the word slot given by the 5-bit word counter.
    - Operand order: x1, y1, x2, y2. Words little-endian (word 0 = bits [DW-1:0]).
    - The last word of each operand uses only 2M-(OPW-1)*DW = 2 bits; upper bits are discarded.
    - The first accepted word clears err_trit/err_timeout and sets busy.
  - Trit check: every 2-bit pair in the used bits of each accepted word is checked. A 2'b11 sets an internal bad flag.
  - After word 4*OPW-1 is accepted:
    - bad set -> err_trit = 1, busy = 0, back to IDLE; core_reset never drops and no result is emitted.
    - bad clear -> START.
  - START (1 cycle): in_ready = 0, core_reset = 1. Next state is BUSY.
  - BUSY: core_reset = 0; watchdog counts up from 0.
    - core_done = 1 -> DRAIN.
    - Watchdog reaches TIMEOUT-1 without core_done -> err_timeout = 1, core_reset = 1, busy = 0, back to IDLE.
    - core_done wins if both occur in the same cycle.
  - DRAIN: core_reset stays 0, so core_out is held by the core.
    - out_valid = 1; out_data = core_out word[k]; the final word is zero-padded above bit 12M-(RW-1)*DW-1 (12 valid bits).
    - out_last = 1 when k = RW-1.
    - k advances only on out_valid&out_ready. While stalled, out_data/out_last are stable.
    - Handshake on the last word -> IDLE, core_reset = 1, busy = 0, out_valid = 0.
- Operand registers are stable from START until the next accepted word in LOAD; the core reads x2/y2 continuously.
- in_valid outside LOAD is ignored; no data loss, since in_ready = 0.
- An async reset in any state aborts immediately, with no residual output handshake.
- Registered outputs only; no combinational path from in_valid/out_ready to any output except via state.

Decomposition:
- Shared include (inc.v): M and derived WIDTH/W6 already defined there; add DW, OPW, RW and the state encodings IDLE=2'd0, START=2'd1, BUSY=2'd2, DRAIN=2'd3.
- One sub-module, tp_trit_check: combinational DW-bit word plus valid-bit count -> invalid-trit flag.
- The FSM, counters and word mux live in the top.

Test Plan:
- Reset:
  - Stimulus: reset_n low mid-clock.
  - Response: core_reset = 1 and out_valid = 0 immediately; in_ready = 1 on the first clk after release.
- Nominal load and drain:
  - Stimulus: 28 words, all 0 except x1 word0 = 32'h00000001. Stub core raises core_done 50 cycles after core_reset falls, with core_out word i = i.
  - Response: core_x1 = 194'h1, others 0; core_reset falls 2 cycles after the 28th handshake. Output words 0..36 = 0..36, out_last only on word 36, word 36 upper 20 bits = 0.
- Backpressure:
  - Stimulus: out_ready pattern 1,0,0,1,0,1... during DRAIN.
  - Response: exactly 37 transfers, in order; out_data unchanged on stalled cycles.
- Invalid trit:
  - Stimulus: x1 word5 = 32'h00000003.
  - Response: err_trit = 1 after the 28th word, core_reset never 0, out_valid never 1. The next first word clears err_trit.
  - Also: a 2'b11 in the ignored bits [31:2] of x1 word6 does not set err_trit.
- Timeout:
  - Stimulus: TIMEOUT = 100, stub never asserts core_done.
  - Response: err_timeout = 1 on the 100th BUSY cycle, core_reset = 1, state returns to IDLE.
- Mid-drain reset:
  - Stimulus: reset_n low after word 10 transfers.
  - Response: out_valid = 0 asynchronously; after release, a fresh 28-word load completes normally.
